// File: rtl/uart_avm_scheduler.sv
// Round-robin scheduler sharing one Avalon-MM master between an RX byte client and a
// TX byte client of an RS232 UART: poll the status register, then move the data byte.
module uart_avm_scheduler #(
  parameter logic [4:0]  RX_BASE     = 5'd0,
  parameter logic [4:0]  TX_BASE     = 5'd4,
  parameter logic [4:0]  STATUS_BASE = 5'd8,
  parameter int unsigned RX_OK_BIT   = 7,
  parameter int unsigned TX_OK_BIT   = 6
) (
  input  logic        avm_clk,
  input  logic        avm_rst,
  input  logic        rx_req,
  output logic        rx_ack,
  output logic [7:0]  rx_data,
  input  logic        tx_req,
  input  logic [7:0]  tx_data,
  output logic        tx_ack,
  output logic        busy,
  output logic [4:0]  avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest
);

  typedef enum logic [1:0] {S_IDLE, S_POLL, S_XFER} state_t;

  localparam logic GRANT_RX = 1'b0;
  localparam logic GRANT_TX = 1'b1;

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic [4:0]  addr_q, addr_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rx_ack_q, rx_ack_d;
  logic        tx_ack_q, tx_ack_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        busy_q, busy_d;

  logic rx_elig, tx_elig, any_elig, new_grant, ready_bit, other_elig;
  logic unused_readdata;

  // A request raised again in its own ack cycle is not a new request yet.
  assign rx_elig    = rx_req & ~rx_ack_q;
  assign tx_elig    = tx_req & ~tx_ack_q;
  assign any_elig   = rx_elig | tx_elig;
  assign new_grant  = (rx_elig && tx_elig) ? ~last_grant_q : tx_elig;
  assign ready_bit  = (grant_q == GRANT_TX) ? avm_readdata[TX_OK_BIT] : avm_readdata[RX_OK_BIT];
  assign other_elig = (grant_q == GRANT_TX) ? rx_elig : tx_elig;
  assign unused_readdata = ^avm_readdata[31:8];

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_elig) state_d = S_POLL;
      S_POLL:  if (!avm_waitrequest && ready_bit) state_d = S_XFER;
      S_XFER:  if (!avm_waitrequest) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    tx_byte_d    = tx_byte_q;
    addr_d       = addr_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    wdata_d      = wdata_q;
    rx_data_d    = rx_data_q;
    rx_ack_d     = 1'b0;
    tx_ack_d     = 1'b0;
    busy_d       = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (any_elig) begin
          grant_d = new_grant;
          if (new_grant == GRANT_TX) tx_byte_d = tx_data;
          addr_d = STATUS_BASE;
          rd_d   = 1'b1;
          wr_d   = 1'b0;
        end
      end
      S_POLL: begin
        if (!avm_waitrequest) begin
          if (ready_bit) begin
            if (grant_q == GRANT_TX) begin
              rd_d    = 1'b0;
              wr_d    = 1'b1;
              addr_d  = TX_BASE;
              wdata_d = {24'h0, tx_byte_q};
            end else begin
              addr_d = RX_BASE;
            end
          end else if (other_elig) begin
            // Not ready for this client: give the re-poll to the other one.
            grant_d = ~grant_q;
            if (grant_q == GRANT_RX) tx_byte_d = tx_data;
          end
        end
      end
      S_XFER: begin
        if (!avm_waitrequest) begin
          rd_d         = 1'b0;
          wr_d         = 1'b0;
          addr_d       = STATUS_BASE;
          last_grant_d = grant_q;
          if (grant_q == GRANT_RX) begin
            rx_data_d = avm_readdata[7:0];
            rx_ack_d  = 1'b1;
          end else begin
            tx_ack_d  = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      grant_q      <= GRANT_RX;
      last_grant_q <= GRANT_TX;
      tx_byte_q    <= 8'h0;
      addr_q       <= STATUS_BASE;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      wdata_q      <= 32'h0;
      rx_ack_q     <= 1'b0;
      tx_ack_q     <= 1'b0;
      rx_data_q    <= 8'h0;
      busy_q       <= 1'b0;
    end else begin
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      tx_byte_q    <= tx_byte_d;
      addr_q       <= addr_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      wdata_q      <= wdata_d;
      rx_ack_q     <= rx_ack_d;
      tx_ack_q     <= tx_ack_d;
      rx_data_q    <= rx_data_d;
      busy_q       <= busy_d;
    end
  end

  assign avm_address   = addr_q;
  assign avm_read      = rd_q;
  assign avm_write     = wr_q;
  assign avm_writedata = wdata_q;
  assign rx_ack        = rx_ack_q;
  assign tx_ack        = tx_ack_q;
  assign rx_data       = rx_data_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_uart_avm_scheduler.sv
// Bench for uart_avm_scheduler: UART slave model, in-order RX/TX scoreboards,
// directed timing scenarios followed by a randomized two-client phase.
module tb_uart_avm_scheduler;

  logic        avm_clk = 1'b0;
  logic        avm_rst = 1'b1;
  logic        rx_req = 1'b0;
  logic        tx_req = 1'b0;
  logic [7:0]  tx_data = 8'h0;
  logic        rx_ack, tx_ack, busy;
  logic [7:0]  rx_data;
  logic [4:0]  avm_address;
  logic        avm_read, avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = 32'h0;
  logic        avm_waitrequest = 1'b0;

  uart_avm_scheduler dut (
    .avm_clk(avm_clk), .avm_rst(avm_rst),
    .rx_req(rx_req), .rx_ack(rx_ack), .rx_data(rx_data),
    .tx_req(tx_req), .tx_data(tx_data), .tx_ack(tx_ack),
    .busy(busy),
    .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
    .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest)
  );

  always #5 avm_clk = ~avm_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // UART slave model state
  byte unsigned rx_stream[$];
  bit  tx_ok = 1'b0;
  int  poll_fail_left = 0;
  int  hold_cnt = 0;
  bit  ws_rand = 1'b0;
  bit  rand_env = 1'b0;

  // Scoreboards: bytes expected in delivery order
  byte unsigned rx_exp[$];
  byte unsigned tx_exp[$];
  int ack_log[$];

  int stat_reads = 0, rx_reads = 0, wr_done = 0, wr_hi_cyc = 0;
  int rx_acks = 0, tx_acks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic note_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic push_rx(input byte unsigned b);
    rx_stream.push_back(b);
    rx_exp.push_back(b);
  endtask

  // Bus monitor: transfers complete on the edge where waitrequest is low.
  initial begin
    logic        prev_stall;
    logic [4:0]  prev_addr;
    logic        prev_rd, prev_wr;
    logic [31:0] prev_wdata;
    byte unsigned b;
    prev_stall = 1'b0;
    prev_addr = '0; prev_rd = 1'b0; prev_wr = 1'b0; prev_wdata = '0;
    forever begin
      @(posedge avm_clk);
      cyc++;
      if (avm_rst) begin
        prev_stall = 1'b0;
      end else begin
        if (avm_read || avm_write) check("rd_wr_exclusive", {31'h0, avm_read & avm_write}, 32'h0);
        if (prev_stall) begin
          check("stall_hold_ctrl", {25'h0, avm_address, avm_read, avm_write},
                {25'h0, prev_addr, prev_rd, prev_wr});
          check("stall_hold_wdata", avm_writedata, prev_wdata);
        end
        if (avm_write) wr_hi_cyc++;
        prev_stall = (avm_read || avm_write) && avm_waitrequest;
        prev_addr = avm_address; prev_rd = avm_read; prev_wr = avm_write; prev_wdata = avm_writedata;
        if ((avm_read || avm_write) && !avm_waitrequest) begin
          if (avm_read && avm_address == 5'd8) begin
            stat_reads++;
            if (poll_fail_left > 0) poll_fail_left--;
          end else if (avm_read) begin
            check("rx_read_addr", {27'h0, avm_address}, 32'd0);
            rx_reads++;
            if (rx_stream.size() > 0) void'(rx_stream.pop_front());
          end else begin
            check("tx_write_addr", {27'h0, avm_address}, 32'd4);
            wr_done++;
            if (tx_exp.size() == 0) begin
              note_fail("tx_write_unexpected");
            end else begin
              b = tx_exp.pop_front();
              check("tx_writedata", avm_writedata, {24'h0, b});
            end
          end
        end
      end
    end
  end

  // Slave driver: waitrequest and readdata for the cycle just started.
  initial begin
    logic [31:0] noise;
    logic data_cyc;
    forever begin
      @(negedge avm_clk);
      if (rand_env) begin
        if ($urandom_range(0, 3) == 0) tx_ok = ~tx_ok;
        if (rx_stream.size() < 3 && $urandom_range(0, 5) == 0) push_rx(8'($urandom_range(0, 255)));
      end
      noise = $urandom();
      data_cyc = (avm_read && avm_address != 5'd8) || avm_write;
      if (data_cyc && hold_cnt > 0) begin
        avm_waitrequest = 1'b1;
        hold_cnt--;
      end else if (ws_rand && (avm_read || avm_write)) begin
        avm_waitrequest = ($urandom_range(0, 2) == 0);
      end else begin
        avm_waitrequest = 1'b0;
      end
      if (avm_read && avm_address == 5'd8) begin
        noise[7] = (rx_stream.size() > 0);
        noise[6] = tx_ok && (poll_fail_left == 0);
      end else if (avm_read && rx_stream.size() > 0) begin
        noise[7:0] = rx_stream[0];
      end
      avm_readdata = noise;
    end
  end

  // Scoreboard monitor: every ack is matched against the expected stream.
  initial begin
    byte unsigned b;
    forever begin
      @(negedge avm_clk);
      if (rx_ack) begin
        rx_acks++;
        ack_log.push_back(0);
        if (rx_exp.size() == 0) begin
          note_fail("rx_ack_unexpected");
        end else begin
          b = rx_exp.pop_front();
          $display("rx ack: data=%02h expected=%02h", rx_data, b);
          check("rx_data", {24'h0, rx_data}, {24'h0, b});
        end
      end
      if (tx_ack) begin
        tx_acks++;
        ack_log.push_back(1);
        $display("tx ack: writes=%0d acks=%0d", wr_done, tx_acks);
        check("tx_ack_after_write", tx_acks, wr_done);
      end
    end
  end

  task automatic rx_txn(input int gap, output int lat);
    int t0;
    repeat (gap) @(negedge avm_clk);
    rx_req = 1'b1;
    t0 = cyc;
    lat = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge avm_clk);
      if (rx_ack) begin
        lat = cyc - t0;
        break;
      end
    end
    rx_req = 1'b0;
    if (lat < 0) note_fail("rx_ack_timeout");
  endtask

  task automatic tx_txn(input int gap, input logic [7:0] b, output int lat);
    int t0;
    repeat (gap) @(negedge avm_clk);
    tx_data = b;
    tx_exp.push_back(b);
    tx_req = 1'b1;
    t0 = cyc;
    lat = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge avm_clk);
      if (tx_ack) begin
        lat = cyc - t0;
        break;
      end
    end
    tx_req = 1'b0;
    if (lat < 0) note_fail("tx_ack_timeout");
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat2, s0, s1, r0, w0, wh0, a0, t0;
    bit seen;
    avm_rst = 1'b1;
    repeat (2) @(negedge avm_clk);
    check("rst_address", {27'h0, avm_address}, 32'd8);
    check("rst_strobes", {30'h0, avm_read, avm_write}, 32'd0);
    check("rst_writedata", avm_writedata, 32'h0);
    check("rst_acks", {30'h0, rx_ack, tx_ack}, 32'd0);
    check("rst_rx_data_busy", {23'h0, rx_data, busy}, 32'd0);
    avm_rst = 1'b0;
    @(negedge avm_clk);

    // RX only: status 0x80, data 0x5A
    push_rx(8'h5A); tx_ok = 1'b0;
    s0 = stat_reads; r0 = rx_reads;
    rx_txn(0, lat);
    check("rx_only_latency", lat, 3);
    repeat (2) @(negedge avm_clk);
    check("rx_only_status_reads", stat_reads - s0, 1);
    check("rx_only_data_reads", rx_reads - r0, 1);
    check("rx_only_rx_data", {24'h0, rx_data}, 32'h5A);

    // TX only: status 0x40, byte 0xC3
    tx_ok = 1'b1;
    w0 = wr_done; wh0 = wr_hi_cyc;
    tx_txn(0, 8'hC3, lat);
    check("tx_only_latency", lat, 3);
    repeat (2) @(negedge avm_clk);
    check("tx_only_writes", wr_done - w0, 1);
    check("tx_only_write_cycles", wr_hi_cyc - wh0, 1);
    check("tx_only_writedata", avm_writedata, 32'h0000_00C3);

    // Both at once after a TX-last transfer: RX wins, then TX
    push_rx(8'h11);
    ack_log.delete();
    fork
      rx_txn(0, lat);
      tx_txn(0, 8'h3C, lat2);
    join
    repeat (2) @(negedge avm_clk);
    check("tie1_ack_count", ack_log.size(), 2);
    if (ack_log.size() == 2) check("tie1_order", {30'h0, ack_log[0][0], ack_log[1][0]}, 32'b01);

    // After an RX-last transfer, the tie goes to TX first
    push_rx(8'h33);
    rx_txn(0, lat);
    push_rx(8'h44);
    ack_log.delete();
    fork
      rx_txn(0, lat);
      tx_txn(0, 8'h4B, lat2);
    join
    repeat (2) @(negedge avm_clk);
    check("tie2_ack_count", ack_log.size(), 2);
    if (ack_log.size() == 2) check("tie2_order", {30'h0, ack_log[0][0], ack_log[1][0]}, 32'b10);

    // TX: 5 failed polls, then write stalled 3 cycles
    tx_ok = 1'b1; poll_fail_left = 5; hold_cnt = 3;
    s0 = stat_reads; w0 = wr_done; wh0 = wr_hi_cyc; a0 = tx_acks;
    tx_txn(0, 8'hA7, lat);
    check("tx_wait_latency", lat, 11);
    repeat (3) @(negedge avm_clk);
    check("tx_wait_status_reads", stat_reads - s0, 6);
    check("tx_wait_write_cycles", wr_hi_cyc - wh0, 4);
    check("tx_wait_writes", wr_done - w0, 1);
    check("tx_wait_acks", tx_acks - a0, 1);

    // Polling switch: RX not ready, TX pending -> TX served, RX keeps polling
    tx_ok = 1'b1; poll_fail_left = 0;
    s0 = stat_reads; a0 = tx_acks;
    ack_log.delete();
    fork
      rx_txn(0, lat);
      begin
        @(negedge avm_clk);
        tx_txn(0, 8'h5E, lat2);
      end
      begin
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
          @(negedge avm_clk);
          if (tx_acks != a0) begin
            seen = 1'b1;
            break;
          end
        end
        if (!seen) note_fail("switch_tx_ack_timeout");
        s1 = stat_reads;
        check("switch_status_reads_before_tx", s1 - s0, 2);
        repeat (5) @(negedge avm_clk);
        check("switch_rx_polls_resume", {31'h0, (stat_reads - s1) >= 2}, 32'd1);
        push_rx(8'h77);
      end
    join
    repeat (2) @(negedge avm_clk);
    check("switch_ack_count", ack_log.size(), 2);
    if (ack_log.size() == 2) check("switch_order", {30'h0, ack_log[0][0], ack_log[1][0]}, 32'b10);

    // Reset while the RX data read is stalled
    push_rx(8'h99); tx_ok = 1'b0; hold_cnt = 4;
    rx_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge avm_clk);
      if (avm_read && avm_address == 5'd0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) note_fail("rst_xfer_not_reached");
    check("rst_busy_in_xfer", {31'h0, busy}, 32'd1);
    avm_rst = 1'b1;
    #1;
    check("rst_mid_strobes", {30'h0, avm_read, avm_write}, 32'd0);
    check("rst_mid_address", {27'h0, avm_address}, 32'd8);
    check("rst_mid_rx_data", {24'h0, rx_data}, 32'h0);
    check("rst_mid_busy", {31'h0, busy}, 32'd0);
    hold_cnt = 0;
    rx_req = 1'b0;
    a0 = rx_acks;
    repeat (3) @(negedge avm_clk);
    avm_rst = 1'b0;
    repeat (5) @(negedge avm_clk);
    check("rst_no_rx_ack", rx_acks - a0, 0);
    s0 = stat_reads; r0 = rx_reads;
    rx_txn(0, lat);
    check("rst_restart_latency", lat, 3);
    repeat (2) @(negedge avm_clk);
    check("rst_restart_status_reads", stat_reads - s0, 1);
    check("rst_restart_data_reads", rx_reads - r0, 1);

    // Randomized: both clients, random stalls, ready bits and RX arrivals
    ws_rand = 1'b1; rand_env = 1'b1;
    a0 = rx_acks; t0 = tx_acks;
    fork
      begin
        int l;
        for (int i = 0; i < 20; i++) rx_txn($urandom_range(0, 4), l);
      end
      begin
        int l;
        for (int i = 0; i < 20; i++) tx_txn($urandom_range(0, 4), 8'($urandom_range(0, 255)), l);
      end
    join
    rand_env = 1'b0; ws_rand = 1'b0;
    repeat (5) @(negedge avm_clk);
    check("rand_rx_acks", rx_acks - a0, 20);
    check("rand_tx_acks", tx_acks - t0, 20);
    check("rand_tx_exp_drained", tx_exp.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
